// File: rtl/cpldp8_pkg.sv
// rtl/cpldp8_pkg.sv - shared CPLDP-8 widths, tape byte classes and loader states
package cpldp8_pkg;

    localparam int WORD_W  = 12;
    localparam int FIELD_W = 3;
    localparam int BYTE_W  = 8;

    localparam logic [BYTE_W-1:0] LEADER     = 8'o200;
    localparam logic [BYTE_W-1:0] RUBOUT     = 8'o377;
    localparam logic [BYTE_W-1:0] FIELD_MASK = 8'o300;
    localparam logic [BYTE_W-1:0] ORIGIN_BIT = 8'o100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEADER,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_DONE
    } load_state_t;

    typedef enum logic [2:0] {
        BC_RUBOUT,
        BC_FIELD,
        BC_LEADER,
        BC_ORIGIN,
        BC_DATA
    } byte_class_t;

endpackage

// File: rtl/bin_byte_class.sv
// rtl/bin_byte_class.sv - combinational classifier for BIN tape bytes
module bin_byte_class
    import cpldp8_pkg::*;
(
    input  logic [BYTE_W-1:0]  tape_byte,
    output byte_class_t        byte_class,
    output logic [FIELD_W-1:0] field
);

    // Rubout is checked first because it also matches the field-setting pattern.
    always_comb begin
        if (tape_byte == RUBOUT) begin
            byte_class = BC_RUBOUT;
        end else if ((tape_byte & FIELD_MASK) == FIELD_MASK) begin
            byte_class = BC_FIELD;
        end else if (tape_byte[7]) begin
            byte_class = BC_LEADER;
        end else if ((tape_byte & ORIGIN_BIT) != '0) begin
            byte_class = BC_ORIGIN;
        end else begin
            byte_class = BC_DATA;
        end
    end

    assign field = tape_byte[5:3];

endmodule

// File: rtl/bin_loader.sv
// rtl/bin_loader.sv - BIN paper-tape loader writing words into extended memory
module bin_loader
    import cpldp8_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               wr_req,
    input  logic               wr_ack,
    output logic [WORD_W-1:0]  wr_addr,
    output logic [FIELD_W-1:0] wr_field,
    output logic [WORD_W-1:0]  wr_data,
    output logic               busy,
    output logic               done,
    output logic               cksum_err
);

    load_state_t        state, state_next;
    byte_class_t        rx_class;
    logic [FIELD_W-1:0] rx_field;

    logic [WORD_W-1:0]  addr;
    logic [WORD_W-1:0]  sum;
    logic [FIELD_W-1:0] cur_field;
    logic [BYTE_W-1:0]  cur_hi;
    logic [BYTE_W-1:0]  pend_hi;
    logic [BYTE_W-1:0]  pend_lo;
    logic               pend_valid;
    logic               restart_pend;

    logic               rx_fire;
    logic [WORD_W-1:0]  pend_word;
    logic               pend_is_data;

    logic               do_restart;
    logic               take_field;
    logic               take_hi;
    logic               take_lo;
    logic               finish;

    bin_byte_class u_class (
        .tape_byte  (rx_data),
        .byte_class (rx_class),
        .field      (rx_field)
    );

    // The pending frame keeps its raw bytes; word and tag are derived so the
    // checksum can add exactly what came off the tape.
    assign rx_fire      = rx_valid & rx_ready;
    assign pend_word    = {pend_hi[5:0], pend_lo[5:0]};
    assign pend_is_data = pend_valid & ~pend_hi[6];

    assign wr_req = (state == ST_WRITE);
    assign done   = (state == ST_DONE);
    assign busy   = (state == ST_LEADER) || (state == ST_HI) ||
                    (state == ST_LO) || (state == ST_WRITE);

    // Next-state decode and the datapath strobes for the accepted byte.
    always_comb begin
        state_next = state;
        do_restart = 1'b0;
        take_field = 1'b0;
        take_hi    = 1'b0;
        take_lo    = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_LEADER;
                    do_restart = 1'b1;
                end
            end
            ST_LEADER, ST_HI: begin
                if (start) begin
                    state_next = ST_LEADER;
                    do_restart = 1'b1;
                end else if (rx_fire) begin
                    case (rx_class)
                        BC_FIELD: take_field = 1'b1;
                        BC_ORIGIN, BC_DATA: begin
                            take_hi    = 1'b1;
                            state_next = ST_LO;
                        end
                        BC_LEADER: begin
                            if (state == ST_HI) begin
                                finish     = 1'b1;
                                state_next = ST_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LO: begin
                if (start) begin
                    state_next = ST_LEADER;
                    do_restart = 1'b1;
                end else if (rx_fire) begin
                    case (rx_class)
                        BC_RUBOUT: ;
                        BC_FIELD:  take_field = 1'b1;
                        default: begin
                            take_lo    = 1'b1;
                            state_next = pend_is_data ? ST_WRITE : ST_HI;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                if (wr_ack) begin
                    if (restart_pend || start) begin
                        state_next = ST_LEADER;
                        do_restart = 1'b1;
                    end else begin
                        state_next = ST_HI;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, handshake and datapath registers; commit of the previous frame
    // happens when the low byte of the next frame arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rx_ready     <= 1'b0;
            wr_addr      <= '0;
            wr_field     <= '0;
            wr_data      <= '0;
            cksum_err    <= 1'b0;
            addr         <= '0;
            sum          <= '0;
            cur_field    <= '0;
            cur_hi       <= '0;
            pend_hi      <= '0;
            pend_lo      <= '0;
            pend_valid   <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            state    <= state_next;
            rx_ready <= (state_next == ST_LEADER) || (state_next == ST_HI) ||
                        (state_next == ST_LO);
            if (state == ST_WRITE && start) begin
                restart_pend <= 1'b1;
            end
            if (do_restart) begin
                sum          <= '0;
                addr         <= '0;
                cur_field    <= '0;
                pend_valid   <= 1'b0;
                cksum_err    <= 1'b0;
                restart_pend <= 1'b0;
            end
            if (take_field) begin
                cur_field <= rx_field;
            end
            if (take_hi) begin
                cur_hi <= rx_data;
            end
            if (take_lo) begin
                pend_valid <= 1'b1;
                pend_hi    <= cur_hi;
                pend_lo    <= rx_data;
                if (pend_valid) begin
                    sum <= sum + {4'b0, pend_hi} + {4'b0, pend_lo};
                    if (pend_is_data) begin
                        wr_addr  <= addr;
                        wr_field <= cur_field;
                        wr_data  <= pend_word;
                        addr     <= addr + 12'd1;
                    end else begin
                        addr <= pend_word;
                    end
                end
            end
            if (finish) begin
                cksum_err <= !pend_valid || (pend_word != sum);
            end
        end
    end

endmodule

// File: tb/tb_bin_loader.sv
// tb/tb_bin_loader.sv - scoreboard bench for the BIN tape loader
module tb_bin_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_req;
    logic        wr_ack;
    logic [11:0] wr_addr;
    logic [2:0]  wr_field;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic        cksum_err;

    int          tests = 0;
    int          fails = 0;
    int          ack_delay = 0;
    int          gap = 0;
    int          writes_seen = 0;
    logic [26:0] exp_q[$];
    logic [7:0]  tape[$];

    bin_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_req    (wr_req),
        .wr_ack    (wr_ack),
        .wr_addr   (wr_addr),
        .wr_field  (wr_field),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .cksum_err (cksum_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    // Memory side: acks after ack_delay cycles, checks each write against the
    // scoreboard and that address/data/field held still with rx_ready low.
    initial begin : mem_monitor
        logic [26:0] snap;
        logic [26:0] cur;
        logic [26:0] exp_w;
        logic        in_write;
        logic        stable;
        int          wait_n;
        wr_ack   = 1'b0;
        in_write = 1'b0;
        stable   = 1'b1;
        wait_n   = 0;
        snap     = '0;
        forever begin
            @(negedge clk);
            cur = {wr_field, wr_addr, wr_data};
            if (wr_ack) begin
                wr_ack = 1'b0;
            end else if (wr_req) begin
                if (!in_write) begin
                    in_write = 1'b1;
                    snap     = cur;
                    stable   = 1'b1;
                    wait_n   = 0;
                end else if (cur != snap) begin
                    stable = 1'b0;
                end
                if (rx_ready) stable = 1'b0;
                if (wait_n >= ack_delay) begin
                    wr_ack   = 1'b1;
                    in_write = 1'b0;
                    writes_seen++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got f%0o a%0o d%0o, expected no write",
                                 cur[26:24], cur[23:12], cur[11:0]);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("write_fld_addr_data", {5'b0, cur}, {5'b0, exp_w});
                    end
                    check("write_stable_no_ready", {31'b0, stable}, 32'd1);
                end else begin
                    wait_n++;
                end
            end else begin
                in_write = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("FAIL rx_timeout: byte %0o not accepted, expected rx_ready", b);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic add_frame(input logic is_origin, input logic [11:0] w);
        tape.push_back({1'b0, is_origin, w[11:6]});
        tape.push_back({2'b00, w[5:0]});
    endtask

    task automatic add_leader(input int n);
        repeat (n) tape.push_back(8'o200);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic play_tape(input string name, input logic exp_err, input int exp_writes);
        writes_seen = 0;
        pulse_start();
        check({name, "_busy_armed"}, {31'b0, busy}, 32'd1);
        check({name, "_done_cleared"}, {31'b0, done}, 32'd0);
        check({name, "_err_cleared"}, {31'b0, cksum_err}, 32'd0);
        foreach (tape[i]) send_byte(tape[i]);
        check({name, "_done"}, {31'b0, done}, 32'd1);
        check({name, "_cksum_err"}, {31'b0, cksum_err}, {31'b0, exp_err});
        check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
        check({name, "_write_count"}, writes_seen, exp_writes);
        check({name, "_scoreboard_empty"}, exp_q.size(), 32'd0);
        tape.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
        check({name, "_wr_req"}, {31'b0, wr_req}, 32'd0);
        check({name, "_wr_addr"}, {20'b0, wr_addr}, 32'd0);
        check({name, "_wr_field"}, {29'b0, wr_field}, 32'd0);
        check({name, "_wr_data"}, {20'b0, wr_data}, 32'd0);
        check({name, "_busy"}, {31'b0, busy}, 32'd0);
        check({name, "_done"}, {31'b0, done}, 32'd0);
        check({name, "_cksum_err"}, {31'b0, cksum_err}, 32'd0);
    endtask

    // Basic tape: origin 0200, data 1234, 5670. Raw bytes summed:
    // 0102+0000+0012+0034+0056+0070 = 0316.
    task automatic build_basic(input logic [11:0] cks);
        add_leader(4);
        add_frame(1'b1, 12'o0200);
        add_frame(1'b0, 12'o1234);
        add_frame(1'b0, 12'o5670);
        add_frame(1'b0, cks);
        add_leader(1);
        exp_q.push_back({3'd0, 12'o0200, 12'o1234});
        exp_q.push_back({3'd0, 12'o0201, 12'o5670});
    endtask

    initial begin : stimulus
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Clean tape with correct checksum.
        build_basic(12'o0316);
        play_tape("basic", 1'b0, 2);

        // Same tape, checksum off by one.
        build_basic(12'o0317);
        play_tape("bad_cks", 1'b1, 2);

        // Field 2 set after the origin; address wraps 7777 -> 0000.
        // Sum excludes 0320: 0177+0077+0043+0021+0007+0065 = 0456.
        add_leader(4);
        add_frame(1'b1, 12'o7777);
        tape.push_back(8'o320);
        add_frame(1'b0, 12'o4321);
        add_frame(1'b0, 12'o0765);
        add_frame(1'b0, 12'o0456);
        add_leader(1);
        exp_q.push_back({3'd2, 12'o7777, 12'o4321});
        exp_q.push_back({3'd2, 12'o0000, 12'o0765});
        play_tape("field_wrap", 1'b0, 2);

        // Rubouts in leader, mid-frame and between frames, with valid gaps.
        gap = 2;
        add_leader(2);
        tape.push_back(8'o377);
        add_leader(2);
        tape.push_back(8'o102);
        tape.push_back(8'o377);
        tape.push_back(8'o000);
        tape.push_back(8'o377);
        tape.push_back(8'o012);
        tape.push_back(8'o377);
        tape.push_back(8'o034);
        add_frame(1'b0, 12'o5670);
        tape.push_back(8'o003);
        tape.push_back(8'o377);
        tape.push_back(8'o016);
        add_leader(1);
        exp_q.push_back({3'd0, 12'o0200, 12'o1234});
        exp_q.push_back({3'd0, 12'o0201, 12'o5670});
        play_tape("rubout_gaps", 1'b0, 2);
        gap = 0;

        // Slow memory: ack 10 cycles late.
        ack_delay = 10;
        build_basic(12'o0316);
        play_tape("slow_ack", 1'b0, 2);
        ack_delay = 0;

        // Single frame: its word is the checksum over an empty sum.
        add_leader(2);
        add_frame(1'b0, 12'o0000);
        add_leader(1);
        play_tape("single_frame", 1'b0, 0);

        // Reset while a write is outstanding.
        ack_delay = 40;
        writes_seen = 0;
        add_leader(2);
        add_frame(1'b1, 12'o0100);
        add_frame(1'b0, 12'o0777);
        add_frame(1'b0, 12'o0555);
        pulse_start();
        foreach (tape[i]) send_byte(tape[i]);
        tape.delete();
        n = 0;
        while (!wr_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midwrite_wr_req_seen", {31'b0, wr_req}, 32'd1);
        check("midwrite_wr_addr", {20'b0, wr_addr}, 32'o0100);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midwrite_async_drop", {31'b0, wr_req}, 32'd0);
        @(negedge clk);
        check_reset_outputs("midwrite_reset");
        check("midwrite_no_ack", writes_seen, 32'd0);
        reset_n = 1'b1;
        ack_delay = 0;
        exp_q.delete();
        @(negedge clk);

        build_basic(12'o0316);
        play_tape("after_reset", 1'b0, 2);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
